alu_cmd_sequencer: RTL
======================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have one parameter: LENGTH, default 5, operand width in bits (matches the ALU operand width).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  4  ALU opcode
- cmd_a, cmd_b  in  LENGTH each  operands
- alu_enable  out  1  ALU enable
- alu_control  out  4  ALU opcode
- alu_a, alu_b  out  LENGTH each  ALU operands
- alu_result  in  2*LENGTH  ALU Result
- alu_carry, alu_overflow, alu_negative, alu_zero  in  1 each  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_result  out  2*LENGTH  captured result
- rsp_flags  out  4  {carry, overflow, negative, zero}
- rsp_err  out  1  illegal opcode indication

Function
REQ-004 The block SHALL implement FSM states IDLE, EXEC1, EXEC2, CAPT, RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command is accepted at a rising edge with cmd_valid=1 in IDLE.
REQ-006 On accept, the block SHALL register cmd_op, cmd_a and cmd_b, and SHALL move to EXEC1.
REQ-007 alu_a, alu_b and alu_control SHALL present the registered command in every state; alu_enable SHALL be 1 in EXEC1 and EXEC2 only.
REQ-008 Operations SHALL be issued for two consecutive enabled cycles, so the ALU's registered negative, zero and overflow flags reflect the new result.
REQ-009 EXEC1 SHALL go to EXEC2, EXEC2 to CAPT, and CAPT to RESP unconditionally.
REQ-010 At the CAPT-to-RESP edge the block SHALL latch alu_result into rsp_result and {alu_carry, alu_overflow, alu_negative, alu_zero} into rsp_flags.
REQ-011 rsp_valid SHALL be 1 only in RESP; rsp_result, rsp_flags and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-012 RESP SHALL go to IDLE on the edge with rsp_ready=1; a new command SHALL NOT be accepted in that same cycle (cmd_ready=0 in RESP).
REQ-013 Latency SHALL be rsp_valid high exactly 4 cycles after the accept edge; maximum throughput is one command per 5 cycles.
REQ-014 cmd_valid in non-IDLE states SHALL be ignored; the cmd_* inputs SHALL NOT affect alu_* outputs after acceptance.
REQ-015 Width rules: the block SHALL pass operands unchanged, with no sign extension; rsp_result SHALL be exactly 2*LENGTH bits from the ALU.

Reset
REQ-016 While rst=1 at a rising edge, the state SHALL become IDLE, and alu_enable, rsp_valid, rsp_err, rsp_result, rsp_flags, alu_a, alu_b and alu_control SHALL be 0.
REQ-017 rst SHALL take priority over all other inputs and SHALL abort any in-flight command with no response.

Configuration
REQ-018 With macro SEQ_OPCODE_CHECK_EN defined, an accepted cmd_op > 9 SHALL go IDLE->RESP directly, never assert alu_enable, and return rsp_result=0, rsp_flags=0, rsp_err=1.
REQ-019 Without SEQ_OPCODE_CHECK_EN, all opcodes SHALL follow the normal flow and rsp_err SHALL be tied to 0.

Structure
REQ-020 Shared package alu_pkg SHALL hold:
- opcode constants OP_SUM=0, OP_SUB=1, OP_NEG_B=2, OP_MULT=3, OP_AND=4, OP_OR=5, OP_NEG_A=6, OP_XOR=7, OP_SHIFT_L=8, OP_SHIFT_R=9, OP_MAX=9
- flag bit indices FLG_C=3, FLG_V=2, FLG_N=1, FLG_Z=0
- the sequencer state typedef
REQ-021 The block SHALL have no sub-module; the ALU is external, and the bench SHALL instantiate the sequencer connected to the ALU.

Verification (LENGTH=5, ALU attached)
REQ-022 SUM: A=3, B=4 -> rsp_result=10'h007, rsp_flags=4'b0000, rsp_valid 4 cycles after accept.
REQ-023 SUB: A=2, B=5 -> rsp_result=10'h3FD, carry=1, negative=1, zero=0.
REQ-024 SUM: A=5'h1D, B=3 -> rsp_result=0, zero=1, carry=1; then MULT: A=5'h1E, B=3 -> rsp_result=10'h3FA, negative=1, overflow=0.
REQ-025 Backpressure: rsp_ready held low 6 cycles -> rsp_valid and data stable, cmd_ready=0 throughout, single handshake then IDLE.
REQ-026 Reset: rst asserted during EXEC2 -> next cycle IDLE, all outputs 0, no response issued; the next command completes normally.
REQ-027 SEQ_OPCODE_CHECK_EN: cmd_op=4'd12 -> alu_enable never 1, rsp_valid 1 cycle after accept, rsp_err=1, rsp_result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, flag bit positions and command-sequencer state encoding.
package alu_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned FLG_W = 4;

    localparam logic [OP_W-1:0] OP_SUM     = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB     = 4'd1;
    localparam logic [OP_W-1:0] OP_NEG_B   = 4'd2;
    localparam logic [OP_W-1:0] OP_MULT    = 4'd3;
    localparam logic [OP_W-1:0] OP_AND     = 4'd4;
    localparam logic [OP_W-1:0] OP_OR      = 4'd5;
    localparam logic [OP_W-1:0] OP_NEG_A   = 4'd6;
    localparam logic [OP_W-1:0] OP_XOR     = 4'd7;
    localparam logic [OP_W-1:0] OP_SHIFT_L = 4'd8;
    localparam logic [OP_W-1:0] OP_SHIFT_R = 4'd9;
    localparam logic [OP_W-1:0] OP_MAX     = 4'd9;

    localparam int unsigned FLG_C = 3;
    localparam int unsigned FLG_V = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_Z = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC1 = 3'd1,
        EXEC2 = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Valid/ready command sequencer driving an external ALU with registered flags.
// Optional macro SEQ_OPCODE_CHECK_EN: opcodes above OP_MAX skip the ALU and respond with rsp_err.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned LENGTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_W-1:0]       cmd_op,
    input  logic [LENGTH-1:0]     cmd_a,
    input  logic [LENGTH-1:0]     cmd_b,
    output logic                  alu_enable,
    output logic [OP_W-1:0]       alu_control,
    output logic [LENGTH-1:0]     alu_a,
    output logic [LENGTH-1:0]     alu_b,
    input  logic [2*LENGTH-1:0]   alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic                  alu_negative,
    input  logic                  alu_zero,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*LENGTH-1:0]   rsp_result,
    output logic [FLG_W-1:0]      rsp_flags,
    output logic                  rsp_err
);

    localparam int unsigned RES_W = 2 * LENGTH;

    seq_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [LENGTH-1:0] a_q, a_d;
    logic [LENGTH-1:0] b_q, b_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [FLG_W-1:0]  flags_q, flags_d;
    logic              err_q, err_d;
    logic              ready_q, enable_q, valid_q;

    // Next state plus command and response payload capture
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    a_d  = cmd_a;
                    b_d  = cmd_b;
`ifdef SEQ_OPCODE_CHECK_EN
                    if (cmd_op > OP_MAX) begin
                        state_d = RESP;
                        res_d   = '0;
                        flags_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = EXEC1;
                    end
`else
                    state_d = EXEC1;
`endif
                end
            end
            EXEC1: state_d = EXEC2;
            EXEC2: state_d = CAPT;
            CAPT: begin
                // N/Z/V are valid here: the second enabled cycle refreshed them from the new result
                state_d        = RESP;
                res_d          = alu_result;
                flags_d[FLG_C] = alu_carry;
                flags_d[FLG_V] = alu_overflow;
                flags_d[FLG_N] = alu_negative;
                flags_d[FLG_Z] = alu_zero;
                err_d          = 1'b0;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, payload and registered handshake/enable outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            enable_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            ready_q  <= (state_d == IDLE);
            enable_q <= (state_d == EXEC1) || (state_d == EXEC2);
            valid_q  <= (state_d == RESP);
        end
    end

    assign cmd_ready   = ready_q;
    assign alu_enable  = enable_q;
    assign alu_control = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_valid   = valid_q;
    assign rsp_result  = res_q;
    assign rsp_flags   = flags_q;
    assign rsp_err     = err_q;

endmodule
